div_unit: RTL and testbench

- Parametrised multi-cycle integer divider for the execute stage.
- Supplies the div/mod results (signed and unsigned, quotient or remainder) that the single-cycle ALU cannot produce combinationally.
- Radix-2 restoring algorithm: one quotient bit per cycle.
- valid/ready handshakes on both the request side and the result side, plus a pipeline flush input.

---
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit -- multi-cycle radix-2 restoring integer divider.
//
// Produces the quotient or remainder of div_src1 / div_src2, signed or
// unsigned, one quotient bit per cycle. Request side and result side each use
// a valid/ready handshake; flush aborts any operation and drops its result.
//
// Ports:
//   clk        core clock, rising edge
//   resetn     asynchronous active-low reset
//   flush      abort in-flight op / drop pending result
//   div_valid  request valid            div_ready  unit idle, can accept
//   div_signed 1: two's complement      div_mod    1: remainder, 0: quotient
//   div_src1   dividend                 div_src2   divisor
//   res_valid  result valid             res_ready  consumer takes result
//   div_result quotient or remainder, held stable while res_valid is high
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic             div_mod,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] div_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend, shifted out while quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor (magnitude after PREP)
    logic [WIDTH-1:0] src1_q, src1_d;     // original dividend for divide-by-zero
    logic [WIDTH-1:0] result_q, result_d;
    logic             signed_q, signed_d;
    logic             mod_q, mod_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;

    // The shifted remainder can reach 2*divisor-1, so the trial subtraction
    // needs one extra bit; its MSB is the borrow (negative result).
    logic [WIDTH:0]   trial;
    logic             sign1, sign2;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign sign1 = signed_q & quo_q[WIDTH-1];
    assign sign2 = signed_q & dvs_q[WIDTH-1];
    assign q_fix = q_neg_q ? -quo_q : quo_q;
    assign r_fix = r_neg_q ? -rem_q : rem_q;

    assign div_ready  = (state_q == S_IDLE);
    assign res_valid  = (state_q == S_DONE);
    assign div_result = result_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        src1_d   = src1_q;
        result_d = result_q;
        signed_d = signed_q;
        mod_d    = mod_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (div_valid) begin
                    quo_d    = div_src1;
                    dvs_d    = div_src2;
                    src1_d   = div_src1;
                    signed_d = div_signed;
                    mod_d    = div_mod;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                quo_d   = sign1 ? -quo_q : quo_q;
                dvs_d   = sign2 ? -dvs_q : dvs_q;
                q_neg_d = sign1 ^ sign2;
                r_neg_d = sign1;
                dz_d    = (dvs_q == '0);
                rem_d   = '0;
                cnt_d   = CNT_W'(WIDTH);
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Most-negative / -1 needs no special case: the magnitude
                // quotient is already 2^(WIDTH-1) and q_neg is clear.
                if (dz_q) begin
                    result_d = mod_q ? src1_q : '1;
                end else begin
                    result_d = mod_q ? r_fix : q_fix;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush beats everything, including an accept in IDLE.
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            src1_q   <= '0;
            result_q <= '0;
            signed_q <= 1'b0;
            mod_q    <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            src1_q   <= src1_d;
            result_q <= result_d;
            signed_q <= signed_d;
            mod_q    <= mod_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dz_q     <= dz_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed vector bench for div_unit.
// A 32-bit instance runs a table of hand-computed vectors plus handshake,
// flush and reset sequences; an 8-bit instance runs a corner-value sweep over
// all four op modes against a behavioural model.
module tb_div_unit;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 32-bit instance
    logic        flush32, v32, sg32, md32, rr32;
    logic [31:0] a32, b32;
    logic        rdy32, rv32;
    logic [31:0] res32;

    div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .flush(flush32),
        .div_valid(v32), .div_ready(rdy32), .div_signed(sg32), .div_mod(md32),
        .div_src1(a32), .div_src2(b32),
        .res_valid(rv32), .res_ready(rr32), .div_result(res32)
    );

    // 8-bit instance
    logic        flush8, v8, sg8, md8, rr8;
    logic [7:0]  a8, b8;
    logic        rdy8, rv8;
    logic [7:0]  res8;

    div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .flush(flush8),
        .div_valid(v8), .div_ready(rdy8), .div_signed(sg8), .div_mod(md8),
        .div_src1(a8), .div_src2(b8),
        .res_valid(rv8), .res_ready(rr8), .div_result(res8)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Result must not move while the consumer stalls.
    logic        stall_prev = 1'b0;
    logic [31:0] res_prev   = '0;
    always @(negedge clk) begin
        if (resetn && stall_prev) begin
            n_vec++;
            assert (res32 === res_prev)
            else begin
                n_err++;
                $display("FAIL stall_hold: got %h, expected %h", res32, res_prev);
            end
        end
        stall_prev <= rv32 & ~rr32;
        res_prev   <= res32;
    end

    // Issue one request on a 32-bit idle unit, scramble inputs after the
    // accept edge, and count edges until res_valid (lat==1 is the first edge
    // after acceptance). Leaves the result pending.
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic m, output logic [31:0] r, output int lat);
        @(negedge clk);
        a32 = a; b32 = b; sg32 = s; md32 = m; v32 = 1'b1; rr32 = 1'b0;
        @(posedge clk); #1;
        v32 = 1'b0; a32 = ~a; b32 = b ^ 32'h5A5A_0F0F; sg32 = ~s; md32 = ~m;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (rv32) break;
        end
        r = res32;
    endtask

    task automatic retire32();
        @(negedge clk); rr32 = 1'b1;
        @(posedge clk); #1; rr32 = 1'b0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic m, output logic [7:0] r, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; sg8 = s; md8 = m; v8 = 1'b1; rr8 = 1'b0;
        @(posedge clk); #1;
        v8 = 1'b0; a8 = ~a; b8 = ~b;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (rv8) break;
        end
        r = res8;
        @(negedge clk); rr8 = 1'b1;
        @(posedge clk); #1; rr8 = 1'b0;
    endtask

    function automatic logic [7:0] ref8(logic [7:0] a, logic [7:0] b, logic s, logic m);
        int          sa, sb;
        logic [31:0] t;
        if (b == 8'd0) return m ? a : 8'hFF;
        if (!s) return m ? (a % b) : (a / b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        t  = m ? 32'(sa % sb) : 32'(sa / sb);
        return t[7:0];
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        m;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl[18];
        logic [31:0] r;
        logic [31:0] held;
        int          lat;
        int          acc[2];
        int          nacc;
        bit          seen;
        logic [7:0]  pat[10];
        logic [7:0]  r8;

        tbl[0]  = '{32'd100,       32'd7,          1'b0, 1'b0, 32'd14};
        tbl[1]  = '{32'd100,       32'd7,          1'b0, 1'b1, 32'd2};
        tbl[2]  = '{32'hFFFF_FFF9, 32'd2,          1'b1, 1'b0, 32'hFFFF_FFFD};
        tbl[3]  = '{32'hFFFF_FFF9, 32'd2,          1'b1, 1'b1, 32'hFFFF_FFFF};
        tbl[4]  = '{32'd7,         32'hFFFF_FFFE,  1'b1, 1'b1, 32'd1};
        tbl[5]  = '{32'd7,         32'hFFFF_FFFE,  1'b1, 1'b0, 32'hFFFF_FFFD};
        tbl[6]  = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000};
        tbl[7]  = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0};
        tbl[8]  = '{32'h1234_5678, 32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF};
        tbl[9]  = '{32'h1234_5678, 32'd0,          1'b0, 1'b1, 32'h1234_5678};
        tbl[10] = '{32'h1234_5678, 32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF};
        tbl[11] = '{32'h1234_5678, 32'd0,          1'b1, 1'b1, 32'h1234_5678};
        tbl[12] = '{32'hFFFF_FFF9, 32'd2,          1'b0, 1'b0, 32'h7FFF_FFFC};
        tbl[13] = '{32'hFFFF_FFF9, 32'd2,          1'b0, 1'b1, 32'd1};
        tbl[14] = '{32'h8000_0001, 32'd0,          1'b1, 1'b1, 32'h8000_0001};
        tbl[15] = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 1'b0, 32'd0};
        tbl[16] = '{32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000};
        tbl[17] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, 1'b0, 32'd1};

        pat = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h7F, 8'h80, 8'h81, 8'hF9, 8'hFE, 8'hFF};

        resetn = 1'b0;
        flush32 = 1'b0; v32 = 1'b0; sg32 = 1'b0; md32 = 1'b0; rr32 = 1'b0; a32 = '0; b32 = '0;
        flush8  = 1'b0; v8  = 1'b0; sg8  = 1'b0; md8  = 1'b0; rr8  = 1'b0; a8  = '0; b8  = '0;
        #1;
        chk("rst_ready", 32'(rdy32), 32'd1);
        chk("rst_valid", 32'(rv32), 32'd0);
        chk("rst_result", res32, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); resetn = 1'b1;

        // Table vectors
        for (int i = 0; i < 18; i++) begin
            op32(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, r, lat);
            $display("vec %0d: %h / %h s=%0d m=%0d -> %h (lat %0d)",
                     i, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].m, r, lat);
            chk($sformatf("vec%0d_result", i), r, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
            retire32();
            chk($sformatf("vec%0d_retire_valid", i), 32'(rv32), 32'd0);
            chk($sformatf("vec%0d_retire_ready", i), 32'(rdy32), 32'd1);
        end

        // Backpressure: 1000/3 held for 10 stalled cycles
        op32(32'd1000, 32'd3, 1'b0, 1'b0, held, lat);
        $display("stall op: 1000/3 -> %h", held);
        chk("stall_first", held, 32'd333);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("stall_result", res32, 32'd333);
            chk("stall_valid", 32'(rv32), 32'd1);
            chk("stall_ready", 32'(rdy32), 32'd0);
        end
        retire32();
        chk("release_valid", 32'(rv32), 32'd0);
        chk("release_ready", 32'(rdy32), 32'd1);

        // Back-to-back: valid and res_ready held high. Accept edges are one
        // op period apart: PREP + 32 ITER + FIX + DONE + the IDLE accept
        // cycle, i.e. WIDTH+3 busy cycles between accepts -> 36 edges.
        @(negedge clk);
        a32 = 32'd100; b32 = 32'd7; sg32 = 1'b0; md32 = 1'b0; v32 = 1'b1; rr32 = 1'b1;
        nacc = 0;
        for (int k = 0; k < 120 && nacc < 2; k++) begin
            if (k > 0) @(negedge clk);
            if (v32 && rdy32) begin
                acc[nacc] = cyc + 1;
                nacc++;
            end
        end
        @(posedge clk); #1; v32 = 1'b0;
        chk("b2b_count", 32'(nacc), 32'd2);
        chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd36);
        $display("back-to-back accepts at cycles %0d and %0d", acc[0], acc[1]);
        for (int k = 0; k < 100 && !rdy32; k++) begin
            @(posedge clk); #1;
        end
        rr32 = 1'b0;
        chk("b2b_drain", 32'(rdy32), 32'd1);

        // Flush during ITER cycle 15
        @(negedge clk);
        a32 = 32'd555; b32 = 32'd5; sg32 = 1'b0; md32 = 1'b0; v32 = 1'b1;
        @(posedge clk); #1; v32 = 1'b0;
        repeat (15) @(posedge clk);   // PREP edge + 14 ITER edges: now in ITER cycle 15
        @(negedge clk); flush32 = 1'b1;
        @(posedge clk); #1; flush32 = 1'b0;
        chk("flush_ready", 32'(rdy32), 32'd1);
        chk("flush_valid", 32'(rv32), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rv32) seen = 1'b1;
        end
        chk("flush_no_result", 32'(seen), 32'd0);
        op32(32'd200, 32'd10, 1'b0, 1'b0, r, lat);
        $display("after flush: 200/10 -> %h", r);
        chk("after_flush_result", r, 32'd20);
        chk("after_flush_latency", 32'(lat), 32'd34);

        // Flush together with res_ready in DONE: dropped
        @(negedge clk); flush32 = 1'b1; rr32 = 1'b1;
        @(posedge clk); #1; flush32 = 1'b0; rr32 = 1'b0;
        chk("flush_done_valid", 32'(rv32), 32'd0);
        chk("flush_done_ready", 32'(rdy32), 32'd1);

        // Flush together with div_valid in IDLE: not accepted
        @(negedge clk);
        a32 = 32'd9; b32 = 32'd3; v32 = 1'b1; flush32 = 1'b1;
        @(posedge clk); #1; v32 = 1'b0; flush32 = 1'b0;
        chk("flush_idle_ready", 32'(rdy32), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rv32 || !rdy32) seen = 1'b1;
        end
        chk("flush_idle_no_op", 32'(seen), 32'd0);

        // Reset pulsed mid-ITER
        @(negedge clk);
        a32 = 32'd77; b32 = 32'd7; v32 = 1'b1;
        @(posedge clk); #1; v32 = 1'b0;
        repeat (10) @(posedge clk);
        #2; resetn = 1'b0; #1;
        chk("midrst_ready", 32'(rdy32), 32'd1);
        chk("midrst_valid", 32'(rv32), 32'd0);
        chk("midrst_result", res32, 32'd0);
        @(negedge clk); resetn = 1'b1;
        op32(32'd100, 32'd7, 1'b0, 1'b0, r, lat);
        $display("after reset: 100/7 -> %h", r);
        chk("after_rst_result", r, 32'd14);
        chk("after_rst_latency", 32'(lat), 32'd34);
        retire32();

        // WIDTH=8 sweep over corner operands and all op modes
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                for (int md = 0; md < 4; md++) begin
                    op8(pat[i], pat[j], md[1], md[0], r8, lat);
                    $display("w8: %h / %h s=%0d m=%0d -> %h (lat %0d)",
                             pat[i], pat[j], md[1], md[0], r8, lat);
                    chk($sformatf("w8_%h_%h_m%0d", pat[i], pat[j], md), 32'(r8),
                        32'(ref8(pat[i], pat[j], md[1], md[0])));
                    chk("w8_latency", 32'(lat), 32'd10);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
